// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared states and command constants for the PIC acknowledge master
package pic_pkg;

  // Sequencer states for the CPU-side INTA / EOI master
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACK1    = 3'd1,
    ST_GAP     = 3'd2,
    ST_ACK2    = 3'd3,
    ST_SERVICE = 3'd4,
    ST_EOI     = 3'd5,
    ST_HOLD    = 3'd6
  } pic_state_e;

  // OCW2 command bytes
  localparam logic [7:0] OCW2_EOI_NONSPEC   = 8'h20;
  localparam logic [7:0] OCW2_EOI_SPEC_BASE = 8'h60;

  // A0 register select: 0 addresses ICW1/OCW2/OCW3, 1 addresses ICW2-4/OCW1
  localparam logic A0_SEL_OCW2 = 1'b0;
  localparam logic A0_SEL_OCW1 = 1'b1;

  // Specific EOI for one IR level (base command with the level in bits 2:0)
  function automatic logic [7:0] ocw2_specific_eoi(input logic [2:0] level);
    return OCW2_EOI_SPEC_BASE | {5'b00000, level};
  endfunction

endpackage

// File: rtl/pic_ack_master_if.sv
// rtl/pic_ack_master_if.sv - INT/INTA, command-write and core-side signals of the PIC master
interface pic_ack_master_if;
  logic       INT;
  logic       int_enable;
  logic       INTA;
  logic       WR;
  logic       RD;
  logic       CS;
  logic       A0;
  logic [7:0] dataBus_in;
  logic [7:0] dataBus_out;
  logic       dataBus_oe;
  logic [7:0] vector;
  logic       vector_valid;
  logic       service_done;
  logic       spurious;
  logic       busy;

  // CPU-side initiator view
  modport master (
    input  INT, int_enable, dataBus_in, service_done,
    output INTA, WR, RD, CS, A0, dataBus_out, dataBus_oe,
           vector, vector_valid, spurious, busy
  );

  // PIC / core view
  modport slave (
    output INT, int_enable, dataBus_in, service_done,
    input  INTA, WR, RD, CS, A0, dataBus_out, dataBus_oe,
           vector, vector_valid, spurious, busy
  );
endinterface

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer for asynchronous request lines, reset to 0
module sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  // Two-stage metastability filter; output lags the input by two clocks
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/pic_ack_master.sv
// rtl/pic_ack_master.sv - INTA double-pulse acknowledge, vector capture and non-specific EOI write
module pic_ack_master
  import pic_pkg::*;
#(
  parameter int unsigned INTA_LOW_CYCLES = 2,
  parameter int unsigned INTA_GAP_CYCLES = 2,
  parameter int unsigned WR_LOW_CYCLES   = 2,
  parameter logic [7:0]  EOI_CMD         = OCW2_EOI_NONSPEC,
  parameter bit          AUTO_EOI        = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  pic_ack_master_if.master  bus
);

  // Phase lengths live in a 3-bit counter, so each phase is 1..8 clocks
  localparam logic [2:0] INTA_LOW_LAST = 3'(INTA_LOW_CYCLES - 1);
  localparam logic [2:0] INTA_GAP_LAST = 3'(INTA_GAP_CYCLES - 1);
  localparam logic [2:0] WR_LOW_LAST   = 3'(WR_LOW_CYCLES - 1);

  pic_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] vector_q, vector_d;
  logic       vector_valid_q, vector_valid_d;

  logic       inta_q, inta_d;
  logic       wr_q, cs_q, strobe_d;
  logic       rd_q;
  logic       a0_q;
  logic [7:0] dout_q, dout_d;
  logic       oe_q, oe_d;
  logic       busy_q, busy_d;
  logic       spurious_q;

  logic       int_s;

  sync2 u_int_sync (
    .clk_i (clk),
    .rst_i (reset),
    .d_i   (bus.INT),
    .q_o   (int_s)
  );

  // Sequencer: each phase reloads cnt on entry and exits on cnt == length-1
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    vector_d       = vector_q;
    vector_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (int_s && bus.int_enable) begin
          state_d = ST_ACK1;
          cnt_d   = '0;
        end
      end
      ST_ACK1: begin
        if (cnt_q == INTA_LOW_LAST) begin
          state_d = ST_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == INTA_GAP_LAST) begin
          state_d = ST_ACK2;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_ACK2: begin
        if (cnt_q == INTA_LOW_LAST) begin
          // The PIC holds the vector valid through the end of the second pulse
          vector_d       = bus.dataBus_in;
          vector_valid_d = 1'b1;
          state_d        = AUTO_EOI ? ST_IDLE : ST_SERVICE;
          cnt_d          = '0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_SERVICE: begin
        // INT and int_enable are deliberately ignored here: no nesting
        if (bus.service_done) begin
          state_d = ST_EOI;
          cnt_d   = '0;
        end
      end
      ST_EOI: begin
        if (cnt_q == WR_LOW_LAST) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_HOLD: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the next state so every strobe leaves a flop in step with the state
  always_comb begin
    inta_d   = ~((state_d == ST_ACK1) || (state_d == ST_ACK2));
    strobe_d = ~(state_d == ST_EOI);
    oe_d     = (state_d == ST_EOI) || (state_d == ST_HOLD);
    dout_d   = oe_d ? EOI_CMD : 8'h00;
    busy_d   = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset drops any sequence in progress at once
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      vector_q       <= 8'h00;
      vector_valid_q <= 1'b0;
      inta_q         <= 1'b1;
      wr_q           <= 1'b1;
      cs_q           <= 1'b1;
      rd_q           <= 1'b1;
      a0_q           <= 1'b0;
      dout_q         <= 8'h00;
      oe_q           <= 1'b0;
      busy_q         <= 1'b0;
      spurious_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      vector_q       <= vector_d;
      vector_valid_q <= vector_valid_d;
      inta_q         <= inta_d;
      wr_q           <= strobe_d;
      cs_q           <= strobe_d;
      rd_q           <= 1'b1;
      a0_q           <= A0_SEL_OCW2;
      dout_q         <= dout_d;
      oe_q           <= oe_d;
      busy_q         <= busy_d;
      // IDLE commits to ACK1 in the same cycle it sees int_s, so there is
      // no window in which a withdrawn INT could be observed before INTA
      spurious_q     <= 1'b0;
    end
  end

  assign bus.INTA         = inta_q;
  assign bus.WR           = wr_q;
  assign bus.CS           = cs_q;
  assign bus.RD           = rd_q;
  assign bus.A0           = a0_q;
  assign bus.dataBus_out  = dout_q;
  assign bus.dataBus_oe   = oe_q;
  assign bus.vector       = vector_q;
  assign bus.vector_valid = vector_valid_q;
  assign bus.spurious     = spurious_q;
  assign bus.busy         = busy_q;

endmodule
